// File: rtl/page_rotator.sv
// rtl/page_rotator.sv - streaming page shifter with triangular per-cell rotation offsets
module page_rotator #(
  parameter int LEN_DATA  = 64,
  parameter int SIZE_PAGE = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LEN_DATA-1:0] data_in,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] data_out,
  output logic                one_done,
  output logic                done
);

  localparam int OW = $clog2(LEN_DATA);
  localparam int JW = (SIZE_PAGE > 1) ? $clog2(SIZE_PAGE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic            mode_r;
  logic            last_r;
  logic            out_end;
  logic [JW-1:0]   j;
  logic [OW-1:0]   off;
  logic [OW:0]     off_sum;
  logic [OW-1:0]   off_next;
  logic            acc_in;
  logic            acc_out;
  logic            page_end;
  logic            page_last;

  // Rotate through a doubled copy so a shift of 0 needs no special case.
  function automatic logic [LEN_DATA-1:0] rotate(input logic [LEN_DATA-1:0] x,
                                                 input logic [OW-1:0] n,
                                                 input logic right);
    logic [2*LEN_DATA-1:0] d;
    d = {x, x};
    if (right) begin
      d = d >> n;
      return d[LEN_DATA-1:0];
    end
    d = d << n;
    return d[2*LEN_DATA-1:LEN_DATA];
  endfunction

  // Handshakes, page bookkeeping and incremental triangular offset.
  always_comb begin
    in_ready  = (state == S_RUN) && (!out_valid || out_ready);
    acc_in    = in_valid && in_ready;
    acc_out   = out_valid && out_ready;
    page_end  = (j == JW'(SIZE_PAGE - 1));
    // Cell 0 carries the last flag, so a one-cell page must use it directly.
    page_last = (j == '0) ? in_last : last_r;
    off_sum   = {1'b0, off} + (OW+1)'(j) + (OW+1)'(1);
    if (off_sum >= (OW+1)'(LEN_DATA)) begin
      off_next = OW'(off_sum - (OW+1)'(LEN_DATA));
    end else begin
      off_next = OW'(off_sum);
    end
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (acc_in && page_end && page_last) state_nx = S_DRAIN;
      S_DRAIN: if (acc_out) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, datapath register and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= 1'b0;
      last_r    <= 1'b0;
      out_end   <= 1'b0;
      j         <= '0;
      off       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      one_done  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nx;
      one_done <= acc_out && out_end;
      done     <= (state == S_DONE);
      if (state == S_IDLE && start) begin
        mode_r <= mode;
        j      <= '0;
        off    <= '0;
        last_r <= 1'b0;
      end
      if (acc_in) begin
        data_out  <= rotate(data_in, off, mode_r);
        out_valid <= 1'b1;
        out_end   <= page_end;
        if (j == '0) last_r <= in_last;
        if (page_end) begin
          j   <= '0;
          off <= '0;
        end else begin
          j   <= j + JW'(1);
          off <= off_next;
        end
      end else if (acc_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_page_rotator.sv
// tb/tb_page_rotator.sv - self-checking bench for page_rotator
module tb_page_rotator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, mode = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       in_ready, out_valid, one_done, done;
  logic [7:0] data_out;

  logic       start8 = 1'b0, valid8 = 1'b0;
  logic       mode8 = 1'b0, last8 = 1'b1, oready8 = 1'b1;
  logic [7:0] din8 = 8'h01;
  logic       ready8, ovalid8, one_done8, done8;
  logic [7:0] dout8;

  page_rotator #(.LEN_DATA(8), .SIZE_PAGE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .one_done(one_done), .done(done)
  );

  page_rotator #(.LEN_DATA(8), .SIZE_PAGE(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .in_valid(valid8),
    .in_ready(ready8), .data_in(din8), .in_last(last8), .out_valid(ovalid8),
    .out_ready(oready8), .data_out(dout8), .one_done(one_done8), .done(done8)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int n_one = 0, n_done = 0, n_out = 0, one_cyc = 0, done_cyc = 0;
  int mj = 0;
  logic mode_m = 1'b0;
  logic use_model = 1'b0;
  logic toggle_en = 1'b0;
  logic hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic        m;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] x, input int n, input logic right);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = right ? {r[0], r[7:1]} : {r[6:0], r[7]};
    return r;
  endfunction

  function automatic int tri_off(input int k);
    return ((k * (k + 1)) / 2) % 8;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = toggle_en ? ~out_ready : 1'b1;
  end

  // Scoreboard monitor: pops on output accept, pushes model values on input accept.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (one_done) begin n_one++; one_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (out_valid) begin
        if (hold_v) chk("stall_hold", data_out, hold_d);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else chk("data_out", data_out, exp_q.pop_front());
          n_out++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = data_out;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (in_valid && in_ready && use_model) begin
        exp_q.push_back(rot8(data_in, tri_off(mj), mode_m));
        mj = (mj + 1) % 4;
      end
    end
  end

  task automatic clear_counts();
    n_one = 0; n_done = 0; n_out = 0; one_cyc = 0; done_cyc = 0;
  endtask

  task automatic do_start(input logic m);
    @(posedge clk); #1;
    mode = m; mode_m = m; mj = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int t;
    in_valid = 1'b1; data_in = d; in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 200) begin @(negedge clk); t++; end
    if (n_done < target) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic page_checks(input int ones, input int outs);
    chk("one_done_count", ones, n_one);
    chk("done_count", 1, n_done);
    chk("done_after_one_done", done_cyc - one_cyc, 1);
    chk("cells_out", outs, n_out);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k, sent, d8c;
    logic [63:0] w8;

    vt[0] = '{m: 1'b0, d: 32'h01010101, e: 32'h40080201};
    vt[1] = '{m: 1'b1, d: 32'h01010101, e: 32'h04208001};
    vt[2] = '{m: 1'b1, d: 32'h40080201, e: 32'h01010101};
    vt[3] = '{m: 1'b1, d: 32'hA5A5A5A5, e: 32'h96B4D2A5};
    vt[4] = '{m: 1'b0, d: 32'hA5A5A5A5, e: 32'h692D4BA5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_one_done", one_done, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Table-driven single-page vectors.
    for (int v = 0; v < 5; v++) begin
      clear_counts();
      use_model = 1'b0;
      for (int c = 0; c < 4; c++) exp_q.push_back(vt[v].e[8*c +: 8]);
      do_start(vt[v].m);
      for (int c = 0; c < 4; c++) send(vt[v].d[8*c +: 8], 1'b1);
      in_valid = 1'b0;
      wait_done(1);
      page_checks(1, 4);
    end

    // Three pages with output backpressure toggling every cycle.
    clear_counts();
    use_model = 1'b1;
    toggle_en = 1'b1;
    do_start(1'b0);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 4; c++) send(8'($urandom), p == 2);
    in_valid = 1'b0;
    wait_done(1);
    toggle_en = 1'b0;
    page_checks(3, 12);

    // Reset in the middle of the first page.
    clear_counts();
    do_start(1'b0);
    for (int c = 0; c < 3; c++) send(8'($urandom), 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_one_done", one_done, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("midrst_no_pulse", n_one + n_done, 0);
    clear_counts();
    do_start(1'b0);
    for (int c = 0; c < 4; c++) send(8'h01 << c, 1'b1);
    in_valid = 1'b0;
    wait_done(1);
    page_checks(1, 4);

    // A start pulse while running must change nothing.
    clear_counts();
    do_start(1'b0);
    send(8'h81, 1'b1);
    send(8'h3C, 1'b1);
    start = 1'b1; mode = 1'b1;
    send(8'h01, 1'b1);
    start = 1'b0; mode = 1'b0;
    send(8'hF0, 1'b1);
    in_valid = 1'b0;
    wait_done(1);
    page_checks(1, 4);

    // Offset wrap on an 8-cell page.
    w8 = 64'h10_20_80_04_40_08_02_01;
    k = 0; sent = 0; d8c = 0;
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    valid8 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done8) d8c++;
      if (ovalid8 && k < 8) begin
        chk($sformatf("wrap_cell%0d", k), dout8, w8[8*k +: 8]);
        k++;
      end
      if (valid8 && ready8) begin
        sent++;
        if (sent == 8) begin @(posedge clk); #1; valid8 = 1'b0; end
      end
    end
    chk("wrap_cells", k, 8);
    chk("wrap_done", d8c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
